// File: rtl/signed_divider_if.sv
// Handshake and operand/result bundle for the signed divider.
// The master drives a request with operands; the slave returns status and results.
interface signed_divider_if #(
    parameter int WIDTH = 8
);
    logic                   start;
    logic [2*WIDTH-1:0]     dividend;
    logic [WIDTH-1:0]       divisor;
    logic                   busy;
    logic                   done;
    logic [WIDTH-1:0]       quotient;
    logic [WIDTH-1:0]       remainder;
    logic                   div_by_zero;
    logic                   overflow;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/signed_divider.sv
// Sequential signed divider: a 2*WIDTH-bit dividend by a WIDTH-bit divisor.
// Operand magnitudes are divided with a restoring algorithm, one bit per
// cycle, then signs are applied and the quotient saturated in a final cycle.
module signed_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    signed_divider_if.slave  bus
);
    localparam int DW = 2 * WIDTH;
    localparam int CW = $clog2(DW + 1);
    localparam logic [CW-1:0]    CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0]    POS_LIM = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic [DW-1:0]    NEG_LIM = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] Q_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] Q_MIN   = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic [WIDTH:0]   prem_r, prem_s;      // partial remainder, one spare bit
    logic [DW-1:0]    qacc_r, qacc_s;      // dividend magnitude shifting into quotient
    logic [WIDTH-1:0] dvs_r, dvs_s;        // divisor magnitude
    logic             sgn_dvd_r, sgn_dvd_s;
    logic             sgn_dvs_r, sgn_dvs_s;
    logic             zero_r, zero_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic [WIDTH-1:0] quo_r, quo_s;
    logic [WIDTH-1:0] rem_r, rem_s;
    logic             dz_r, dz_s;
    logic             ovf_r, ovf_s;
    logic [WIDTH+1:0] shift_s;
    logic [WIDTH+1:0] trial_s;

    // Two's-complement negation at dividend width
    function automatic logic [DW-1:0] neg_dw(input logic [DW-1:0] v);
        return (~v) + {{(DW-1){1'b0}}, 1'b1};
    endfunction

    // Two's-complement negation at result width
    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state, datapath step and result formation
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        prem_s    = prem_r;
        qacc_s    = qacc_r;
        dvs_s     = dvs_r;
        sgn_dvd_s = sgn_dvd_r;
        sgn_dvs_s = sgn_dvs_r;
        zero_s    = zero_r;
        busy_s    = busy_r;
        done_s    = 1'b0;
        quo_s     = quo_r;
        rem_s     = rem_r;
        dz_s      = dz_r;
        ovf_s     = ovf_r;
        shift_s   = {prem_r, qacc_r[DW-1]};
        trial_s   = shift_s - {2'b00, dvs_r};

        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    busy_s = 1'b1;
                    prem_s = {(WIDTH+1){1'b0}};
                    if (bus.divisor != {WIDTH{1'b0}}) begin
                        qacc_s    = bus.dividend[DW-1] ? neg_dw(bus.dividend) : bus.dividend;
                        dvs_s     = bus.divisor[WIDTH-1] ? neg_w(bus.divisor) : bus.divisor;
                        sgn_dvd_s = bus.dividend[DW-1];
                        sgn_dvs_s = bus.divisor[WIDTH-1];
                        zero_s    = 1'b0;
                        cnt_s     = CW'(DW);
                        state_s   = ST_CALC;
                    end else begin
                        // Keep the raw dividend; its low half becomes the remainder
                        qacc_s    = bus.dividend;
                        dvs_s     = {WIDTH{1'b0}};
                        sgn_dvd_s = 1'b0;
                        sgn_dvs_s = 1'b0;
                        zero_s    = 1'b1;
                        cnt_s     = {CW{1'b0}};
                        state_s   = ST_FIX;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                // A set top bit of the trial means a borrow: restore
                if (trial_s[WIDTH+1]) begin
                    prem_s = shift_s[WIDTH:0];
                    qacc_s = {qacc_r[DW-2:0], 1'b0};
                end else begin
                    prem_s = trial_s[WIDTH:0];
                    qacc_s = {qacc_r[DW-2:0], 1'b1};
                end
                cnt_s = cnt_r - CNT_ONE;
                if (cnt_r == CNT_ONE) begin
                    state_s = ST_FIX;
                end else begin
                    state_s = ST_CALC;
                end
            end
            ST_FIX: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
                done_s  = 1'b1;
                if (zero_r) begin
                    quo_s = {WIDTH{1'b0}};
                    rem_s = qacc_r[WIDTH-1:0];
                    dz_s  = 1'b1;
                    ovf_s = 1'b0;
                end else begin
                    dz_s  = 1'b0;
                    rem_s = sgn_dvd_r ? neg_w(prem_r[WIDTH-1:0]) : prem_r[WIDTH-1:0];
                    if (sgn_dvd_r ^ sgn_dvs_r) begin
                        if (qacc_r > NEG_LIM) begin
                            quo_s = Q_MIN;
                            ovf_s = 1'b1;
                        end else begin
                            quo_s = neg_w(qacc_r[WIDTH-1:0]);
                            ovf_s = 1'b0;
                        end
                    end else begin
                        if (qacc_r > POS_LIM) begin
                            quo_s = Q_MAX;
                            ovf_s = 1'b1;
                        end else begin
                            quo_s = qacc_r[WIDTH-1:0];
                            ovf_s = 1'b0;
                        end
                    end
                end
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // Datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r     <= {CW{1'b0}};
            prem_r    <= {(WIDTH+1){1'b0}};
            qacc_r    <= {DW{1'b0}};
            dvs_r     <= {WIDTH{1'b0}};
            sgn_dvd_r <= 1'b0;
            sgn_dvs_r <= 1'b0;
            zero_r    <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            quo_r     <= {WIDTH{1'b0}};
            rem_r     <= {WIDTH{1'b0}};
            dz_r      <= 1'b0;
            ovf_r     <= 1'b0;
        end else begin
            cnt_r     <= cnt_s;
            prem_r    <= prem_s;
            qacc_r    <= qacc_s;
            dvs_r     <= dvs_s;
            sgn_dvd_r <= sgn_dvd_s;
            sgn_dvs_r <= sgn_dvs_s;
            zero_r    <= zero_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            quo_r     <= quo_s;
            rem_r     <= rem_s;
            dz_r      <= dz_s;
            ovf_r     <= ovf_s;
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.quotient    = quo_r;
    assign bus.remainder   = rem_r;
    assign bus.div_by_zero = dz_r;
    assign bus.overflow    = ovf_r;
endmodule

// File: tb/tb_signed_divider.sv
// Self-checking bench for signed_divider (WIDTH=8). Expected results come
// from integer arithmetic in the bench and are queued when a request is
// issued, then popped and compared when done is seen.
module tb_signed_divider;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        logic       ov;
        int         lat;
    } exp_t;

    exp_t sb[$];

    signed_divider_if #(.WIDTH(8)) bus ();

    signed_divider #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [15:0] dvd, input logic [7:0] dvs);
        exp_t e;
        int a, b, qi, ri;
        a = int'($signed(dvd));
        b = int'($signed(dvs));
        if (b == 0) begin
            e.q = 8'h00; e.r = dvd[7:0]; e.dz = 1'b1; e.ov = 1'b0; e.lat = 1;
        end else begin
            qi = a / b;
            ri = a % b;
            e.dz = 1'b0; e.lat = 17; e.r = ri[7:0];
            if (qi > 127) begin
                e.q = 8'h7F; e.ov = 1'b1;
            end else if (qi < -128) begin
                e.q = 8'h80; e.ov = 1'b1;
            end else begin
                e.q = qi[7:0]; e.ov = 1'b0;
            end
        end
        return e;
    endfunction

    // Issue one request, disturb inputs while busy, then compare against the queue
    task automatic run_op(input logic [15:0] dvd, input logic [7:0] dvs,
                          input string name, output exp_t got_exp);
        exp_t e;
        int   cyc;
        bit   seen;
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = dvd; bus.divisor = dvs;
        e = model(dvd, dvs);
        sb.push_back(e);
        @(posedge clk); #1;
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++; $display("FAIL %s busy_after_start: got %b expected 1", name, bus.busy);
        end
        seen = 1'b0; cyc = 0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            bus.start    = (k == 5 && e.lat > 8) ? 1'b1 : 1'b0;
            bus.dividend = 16'($urandom);
            bus.divisor  = 8'($urandom);
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin
                seen = 1'b1; cyc = k;
            end
        end
        bus.start = 1'b0;
        e = sb.pop_front();
        got_exp = e;
        checks++;
        if (!seen) begin
            errors++; $display("FAIL %s done_timeout: got no done expected done after %0d", name, e.lat);
        end else begin
            if (cyc != e.lat) begin
                errors++; $display("FAIL %s latency: got %0d expected %0d", name, cyc, e.lat);
            end
            checks++;
            if (bus.busy !== 1'b0) begin
                errors++; $display("FAIL %s busy_in_done: got %b expected 0", name, bus.busy);
            end
            checks++;
            if (bus.quotient !== e.q) begin
                errors++; $display("FAIL %s quotient: got %h expected %h", name, bus.quotient, e.q);
            end
            checks++;
            if (bus.remainder !== e.r) begin
                errors++; $display("FAIL %s remainder: got %h expected %h", name, bus.remainder, e.r);
            end
            checks++;
            if ({bus.div_by_zero, bus.overflow} !== {e.dz, e.ov}) begin
                errors++; $display("FAIL %s flags dz/ov: got %b%b expected %b%b", name,
                                   bus.div_by_zero, bus.overflow, e.dz, e.ov);
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; bus.start = 1'b0; bus.dividend = 16'h0000; bus.divisor = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow} !== 20'h00000) begin
            errors++; $display("FAIL reset_outputs: got %b%b %h %h %b%b expected all zero", bus.busy, bus.done,
                               bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_basic;
        exp_t e;
        run_op(16'd100, 8'd7, "pos_pos", e);
        run_op(16'hFF9C, 8'd7, "neg_pos", e);
        run_op(16'hFF9C, 8'hF9, "neg_neg", e);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.done !== 1'b0) begin
            errors++; $display("FAIL hold_done_low: got %b expected 0", bus.done);
        end
        checks++;
        if (bus.quotient !== e.q || bus.remainder !== e.r) begin
            errors++; $display("FAIL hold_results: got %h/%h expected %h/%h", bus.quotient, bus.remainder, e.q, e.r);
        end
    endtask

    task automatic test_overflow;
        exp_t e;
        run_op(16'd1000, 8'd3, "ovf_pos", e);
        run_op(16'h8000, 8'h80, "ovf_min_min", e);
        run_op(16'hFF80, 8'h01, "min_exact", e);
        run_op(16'h8000, 8'h01, "ovf_neg", e);
        run_op(16'h7FFF, 8'hFF, "ovf_neg2", e);
    endtask

    task automatic test_div_zero;
        exp_t e;
        run_op(16'h1234, 8'h00, "dz_pos", e);
        run_op(16'hFF9C, 8'h00, "dz_neg", e);
    endtask

    task automatic test_random;
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            run_op(16'($urandom), 8'($urandom_range(1, 255)), "random", e);
        end
    endtask

    // Start held high; only the operands present at each acceptance edge count
    task automatic test_back_to_back;
        exp_t e;
        int   dones;
        logic [15:0] dvd;
        logic [7:0]  dvs;
        dones = 0;
        for (int c = 0; c < 54; c++) begin
            @(negedge clk);
            bus.start = 1'b1;
            if (c % 18 == 0) begin
                dvd = ((c / 18) % 2 == 0) ? 16'd100 : 16'hFC18;
                dvs = ((c / 18) % 2 == 0) ? 8'd7 : 8'hF7;
                sb.push_back(model(dvd, dvs));
            end else begin
                dvd = 16'($urandom);
                dvs = 8'($urandom);
            end
            bus.dividend = dvd; bus.divisor = dvs;
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin
                dones++;
                checks++;
                if (c % 18 != 17) begin
                    errors++; $display("FAIL b2b_period: got done at cycle %0d expected cycle mod 18 = 17", c);
                end
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    checks++;
                    if (bus.quotient !== e.q || bus.remainder !== e.r) begin
                        errors++; $display("FAIL b2b_result: got %h/%h expected %h/%h",
                                           bus.quotient, bus.remainder, e.q, e.r);
                    end
                end
            end
        end
        @(negedge clk); bus.start = 1'b0;
        checks++;
        if (dones != 3) begin
            errors++; $display("FAIL b2b_done_count: got %0d expected 3", dones);
        end
    endtask

    task automatic test_reset_mid_op;
        exp_t e;
        bit   seen;
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 16'd1000; bus.divisor = 8'hF7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow} !== 20'h00000) begin
            errors++; $display("FAIL midop_reset_outputs: got %b%b %h %h %b%b expected all zero", bus.busy, bus.done,
                               bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow);
        end
        seen = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) seen = 1'b1;
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (25) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++; $display("FAIL midop_abort: got done/busy after reset expected none");
        end
        run_op(16'd100, 8'd7, "post_reset", e);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_overflow();
        test_div_zero();
        test_random();
        test_back_to_back();
        test_reset_mid_op();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/signed_divider.md
SIGNED_DIVIDER -- requirements
Module: signed_divider

Interface
REQ-001 Parameter: WIDTH, default 8, divisor/quotient/remainder width; dividend width is 2*WIDTH.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 Port: clk  input  1  clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: start  input  1  request; sampled only in IDLE.
REQ-006 Port: dividend  input  2*WIDTH  signed two's-complement dividend.
REQ-007 Port: divisor  input  WIDTH  signed two's-complement divisor.
REQ-008 Port: busy  output  1  high while an operation is in progress.
REQ-009 Port: done  output  1  one-cycle pulse when results update.
REQ-010 Port: quotient  output  WIDTH  signed quotient, registered.
REQ-011 Port: remainder  output  WIDTH  signed remainder, registered.
REQ-012 Port: div_by_zero  output  1  divisor was zero for the last operation.
REQ-013 Port: overflow  output  1  true quotient outside signed WIDTH range for the last operation.

Function
REQ-014 The FSM SHALL have states IDLE, CALC and FIX; IDLE SHALL be the reset state.
REQ-015 IDLE with start=1 and divisor!=0: capture |dividend|, |divisor|, both sign bits; load iteration counter with 2*WIDTH; go to CALC.
REQ-016 IDLE with start=1 and divisor==0: capture dividend; go directly to FIX.
REQ-017 CALC SHALL perform one unsigned restoring-division step per cycle (shift partial remainder left one bit, trial-subtract |divisor|, set quotient bit); exactly 2*WIDTH steps, then go to FIX.
REQ-018 The internal partial remainder SHALL be WIDTH+1 bits and the internal quotient 2*WIDTH bits, so no intermediate result is lost.
REQ-019 FIX SHALL apply signs in one cycle, register all result outputs, pulse done, and return to IDLE.
REQ-020 Result semantics: quotient truncates toward zero; remainder takes the dividend's sign; dividend = quotient*divisor + remainder whenever overflow=0.
REQ-021 If the signed quotient is > 2^(WIDTH-1)-1, quotient SHALL saturate to 2^(WIDTH-1)-1; if < -2^(WIDTH-1), quotient SHALL saturate to -2^(WIDTH-1); overflow=1 in both cases; remainder stays exact.
REQ-022 Divide by zero: quotient=0, remainder=dividend[WIDTH-1:0], div_by_zero=1, overflow=0.
REQ-023 Latency: start sampled at edge E with divisor!=0 -> done high for the cycle after edge E+2*WIDTH+1 (E+17 at WIDTH=8); divisor==0 -> done high after edge E+1.
REQ-024 busy SHALL be high from edge E through the edge that raises done; busy SHALL be low in the done cycle.
REQ-025 start while busy=1 SHALL be ignored; operand changes after edge E SHALL not affect the result.
REQ-026 start asserted during the done cycle SHALL be accepted (back-to-back operation).
REQ-027 quotient, remainder, div_by_zero and overflow SHALL hold their values until the next FIX.
REQ-028 done SHALL be high for exactly one cycle per accepted start.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, overflow=0, clear the counter and internal registers.
REQ-030 Reset mid-operation SHALL abort without a done pulse; the first start after rst_n deasserts SHALL be processed normally.

Verification
REQ-031 dividend=100, divisor=7 -> done 17 cycles after start edge; quotient=14 (8'h0E), remainder=2, flags 0.
REQ-032 dividend=-100 (16'hFF9C), divisor=7 -> quotient=8'hF2 (-14), remainder=8'hFE (-2); repeat with divisor=-7 -> quotient=8'h0E, remainder=8'hFE.
REQ-033 dividend=1000, divisor=3 -> quotient=8'h7F, remainder=1, overflow=1; dividend=16'h8000, divisor=8'h80 -> quotient=8'h7F, remainder=0, overflow=1; dividend=16'hFF80, divisor=1 -> quotient=8'h80, remainder=0, overflow=0.
REQ-034 dividend=16'h1234, divisor=0 -> done one cycle after start edge; quotient=0, remainder=8'h34, div_by_zero=1.
REQ-035 start held high continuously with alternating operands -> one done per 18 cycles; mid-operation start pulses and operand changes have no effect.
REQ-036 rst_n pulsed low 8 cycles into an operation -> all outputs 0 immediately, no done; the next operation (100/7) returns 14/2.
